// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Sign fix-up and W-form extension happen in a single FIX cycle.
module muldiv_seq #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   len_q, len_d;
   logic [XLEN-1:0] opA_q, opA_d;
   logic [XLEN-1:0] opB_q, opB_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            isW_q, isW_d;
   logic            isMul_q, isMul_d;
   logic            isRem_q, isRem_d;
   logic            negQuo_q, negQuo_d;
   logic            negRem_q, negRem_d;

   logic [2:0]      baseOp;
   logic            opW, opMul, opSigned, opRem, opReserved;
   logic [XLEN-1:0] ext1, ext2, mag1, mag2, dividendRes;
   logic            neg1, neg2, divZero, divOvf;

   logic [XLEN:0]   remShift;
   logic            remFits;
   logic [XLEN-1:0] quoFix, remFix, selFix, finalFix;

   // Decode the incoming op and prepare operands, magnitudes and special cases
   always_comb begin
      baseOp     = op_i[2:0];
      opW        = op_i[3];
      opReserved = (baseOp > 3'd4);
      opMul      = (baseOp == 3'd0);
      opSigned   = (baseOp == 3'd1) || (baseOp == 3'd3);
      opRem      = (baseOp == 3'd3) || (baseOp == 3'd4);
      if (opW) begin
         ext1 = opSigned ? {{(XLEN-32){src1_i[31]}}, src1_i[31:0]}
                         : {{(XLEN-32){1'b0}}, src1_i[31:0]};
         ext2 = opSigned ? {{(XLEN-32){src2_i[31]}}, src2_i[31:0]}
                         : {{(XLEN-32){1'b0}}, src2_i[31:0]};
         divZero = (src2_i[31:0] == 32'd0);
         divOvf  = opSigned && (src1_i[31:0] == 32'h8000_0000)
                            && (src2_i[31:0] == 32'hFFFF_FFFF);
         dividendRes = {{(XLEN-32){src1_i[31]}}, src1_i[31:0]};
      end else begin
         ext1 = src1_i;
         ext2 = src2_i;
         divZero = (src2_i == '0);
         divOvf  = opSigned && (src1_i == {1'b1, {(XLEN-1){1'b0}}})
                            && (src2_i == '1);
         dividendRes = src1_i;
      end
      neg1 = opSigned && ext1[XLEN-1];
      neg2 = opSigned && ext2[XLEN-1];
      mag1 = neg1 ? (~ext1 + 1'b1) : ext1;
      mag2 = neg2 ? (~ext2 + 1'b1) : ext2;
   end

   // Restoring-divide step: shift one dividend bit into the partial remainder
   assign remShift = {acc_q, opA_q[XLEN-1]};
   assign remFits  = (remShift >= {1'b0, opB_q});

   // FIX datapath: undo the magnitude trick, choose the output, extend W forms
   assign quoFix   = negQuo_q ? (~opA_q + 1'b1) : opA_q;
   assign remFix   = negRem_q ? (~acc_q + 1'b1) : acc_q;
   assign selFix   = isMul_q ? acc_q : (isRem_q ? remFix : quoFix);
   assign finalFix = isW_q ? {{(XLEN-32){selFix[31]}}, selFix[31:0]} : selFix;

   // Next-state logic: accept, iterate, fix up, pulse done; flush overrides all
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      acc_d    = acc_q;
      result_d = result_q;
      isW_d    = isW_q;
      isMul_d  = isMul_q;
      isRem_d  = isRem_q;
      negQuo_d = negQuo_q;
      negRem_d = negRem_q;

      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               cnt_d    = '0;
               len_d    = opW ? CW'(32) : CW'(XLEN);
               isW_d    = opW;
               isMul_d  = opMul;
               isRem_d  = opRem;
               negQuo_d = neg1 ^ neg2;
               negRem_d = neg1;
               acc_d    = '0;
               if (opReserved) begin
                  result_d = '0;
                  state_d  = DONE;
               end else if (opMul) begin
                  opA_d   = ext1;
                  opB_d   = ext2;
                  state_d = MUL;
               end else if (divZero) begin
                  result_d = opRem ? dividendRes : '1;
                  state_d  = DONE;
               end else if (divOvf) begin
                  result_d = opRem ? '0 : dividendRes;
                  state_d  = DONE;
               end else begin
                  opA_d   = opW ? (mag1 << 32) : mag1;
                  opB_d   = mag2;
                  state_d = DIV;
               end
            end
         end
         MUL: begin
            if (opB_q[0]) begin
               acc_d = acc_q + opA_q;
            end
            opA_d = opA_q << 1;
            opB_d = opB_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
               state_d = FIX;
            end
         end
         DIV: begin
            acc_d = remFits ? (remShift[XLEN-1:0] - opB_q) : remShift[XLEN-1:0];
            opA_d = {opA_q[XLEN-2:0], remFits};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = finalFix;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush_i) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // State and datapath registers, cleared asynchronously by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         opA_q    <= '0;
         opB_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         isW_q    <= 1'b0;
         isMul_q  <= 1'b0;
         isRem_q  <= 1'b0;
         negQuo_q <= 1'b0;
         negRem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         isW_q    <= isW_d;
         isMul_q  <= isMul_d;
         isRem_q  <= isRem_d;
         negQuo_q <= negQuo_d;
         negRem_q <= negRem_d;
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;

endmodule
